alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer sharing a single ALU instance. Accepts operation requests (aluop, operands) from two clients over valid/ready handshakes and drives the ALU with the granted request. It captures result and flags into a response register and holds them on a valid/ready response channel tagged with the requester id. Sits between the ALU and its clients (e.g. execute stage and a multicycle helper unit).

## Interface
- FIXED_PRIO, 0, 1 = requester 0 always wins contention; 0 = round-robin

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_aluop / req1_aluop  in  aluop_t  operation
- req0_porta, req0_portb / req1_porta, req1_portb  in  32  operands
- alu_aluop  out  aluop_t  to ALU
- alu_porta, alu_portb  out  32  to ALU
- alu_outport  in  32  ALU result
- alu_negative, alu_zero, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_outport  out  32  captured result
- rsp_negative, rsp_zero, rsp_overflow  out  1  captured flags

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: grant computed combinationally from valids. req_ready asserted only for the granted requester, only in IDLE. On handshake: latch aluop/porta/portb/id into operand register, update last_grant, go ISSUE. No valid: stay IDLE.
- Round-robin: both valid → grant the requester not equal to last_grant; one valid → grant it. FIXED_PRIO=1 → req0 wins whenever valid.
- ISSUE: alu_* driven from operand register. At the clock edge, alu_outport and flags captured into the response register. Go RESP.
- RESP: rsp_valid=1, response fields stable. rsp_valid&rsp_ready → IDLE. Otherwise hold with no new acceptance.
- Outside ISSUE: alu_aluop=ALU_ADD, alu_porta=alu_portb=0.
- Flags are passed through unmodified. overflow is meaningful only for ADD/SUB and is whatever the ALU reports otherwise. Undefined aluop codes are forwarded, and the ALU result (0) is returned.
- Requester must hold valid and operands stable until ready. Dropping valid early is a protocol violation, flagged by a bench assertion only.

## Timing
- Reset (nRST=0 at edge): state IDLE, last_grant=1 (req0 wins first contention), rsp_valid=0, rsp_id=0, rsp_outport=0, all rsp flags 0, operand register 0, req*_ready=0 during reset cycle.
- Accept at edge N → ISSUE during cycle N+1 → rsp_valid high from cycle N+2.
- rsp_ready high in the first RESP cycle → IDLE at N+3; next acceptance possible cycle N+3. Minimum 3 cycles per op.
- rsp_ready low: response held indefinitely. Both requesters see ready=0.
- Reset in ISSUE or RESP: pending operation and response discarded, no rsp_valid pulse.
- Request arriving while not IDLE waits. The grant is evaluated only in IDLE, with then-current valids.
- Maximum wait for a continuously valid requester under round-robin: one foreign operation.

## Structure
- cpu_types_pkg: aluop_t, word_t (already present). Add alu_arb_state_t {IDLE, ISSUE, RESP}.
- Sub-module rr_arbiter2: inputs valid[1:0], last_grant, fixed_prio; output one-hot grant. Purely combinational, reused by other shared-resource arbiters.
- Top holds the FSM, operand register, response register and last_grant flop.

## Test plan
- Reset then req0 ADD 0x7FFFFFFF+1 alone, rsp_ready=1 → rsp_valid at accept+2, rsp_id=0, outport 0x80000000, negative=1, overflow=1, zero=0.
- Both valid continuously, req0 SUB 5-5, req1 OR 0xF0|0x0F, after reset → order id 0,1,0,1. Results 0 (zero=1) and 0xFF. FIXED_PRIO=1 → req0 served every time.
- rsp_ready held low 10 cycles after req1 SLT (-1<1) → rsp_valid, rsp_outport=1, id=1 stable all 10 cycles, req0_ready=0 throughout.
- nRST asserted during ISSUE of req0 XOR → next cycle rsp_valid=0, all rsp fields 0. First op after release granted to req0.
- Back-to-back req1 SLL (porta=4, portb=1) then SRL (porta=31, portb=0x80000000), rsp_ready=1 → results 0x10 then 1, exactly 3 cycles between acceptances.
- ALU idle check: alu_porta/portb=0 and alu_aluop=ALU_ADD in every IDLE/RESP cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU operation codes and the
// state encoding of the ALU arbiter/sequencer.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Codes 10..15 are unassigned; the ALU returns 0 for them.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter with round-robin or fixed-priority policy.
// Produces a one-hot grant (or zero when nobody is requesting).
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    // Under contention, round-robin favours the requester not served last.
    always_comb begin
        grant = 2'b00;
        if (fixed_prio) begin
            if (valid[0]) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: arbitrates, issues the granted
// operation for one cycle and holds the tagged result until it is consumed.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   req0_valid,
    output logic   req0_ready,
    input  aluop_t req0_aluop,
    input  word_t  req0_porta,
    input  word_t  req0_portb,
    input  logic   req1_valid,
    output logic   req1_ready,
    input  aluop_t req1_aluop,
    input  word_t  req1_porta,
    input  word_t  req1_portb,
    output aluop_t alu_aluop,
    output word_t  alu_porta,
    output word_t  alu_portb,
    input  word_t  alu_outport,
    input  logic   alu_negative,
    input  logic   alu_zero,
    input  logic   alu_overflow,
    output logic   rsp_valid,
    input  logic   rsp_ready,
    output logic   rsp_id,
    output word_t  rsp_outport,
    output logic   rsp_negative,
    output logic   rsp_zero,
    output logic   rsp_overflow
);

    alu_arb_state_t state;
    logic           last_grant;
    logic [1:0]     grant;

    aluop_t op_aluop;
    word_t  op_porta;
    word_t  op_portb;
    logic   op_id;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO),
        .grant      (grant)
    );

    // Ready only in IDLE and never in a reset cycle, so a grant is a handshake.
    assign req0_ready = nRST && (state == IDLE) && grant[0];
    assign req1_ready = nRST && (state == IDLE) && grant[1];

    always_comb begin
        alu_aluop = ALU_ADD;
        alu_porta = '0;
        alu_portb = '0;
        if (state == ISSUE) begin
            alu_aluop = op_aluop;
            alu_porta = op_porta;
            alu_portb = op_portb;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            op_aluop     <= aluop_t'(4'd0);
            op_porta     <= '0;
            op_portb     <= '0;
            op_id        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_outport  <= '0;
            rsp_negative <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        op_id      <= grant[1];
                        op_aluop   <= grant[1] ? req1_aluop : req0_aluop;
                        op_porta   <= grant[1] ? req1_porta : req0_porta;
                        op_portb   <= grant[1] ? req1_portb : req0_portb;
                        last_grant <= grant[1];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_outport  <= alu_outport;
                    rsp_negative <= alu_negative;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_id       <= op_id;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, vector table plus scoreboard of
// accepted requests, and hand-written contention/hold/reset/back-to-back runs.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        logic   id;
        aluop_t op;
        word_t  a;
        word_t  b;
        word_t  out;
        logic   n;
        logic   z;
        logic   v;
    } vec_t;

    typedef struct {
        vec_t vec;
        int   acc_cycle;
    } sb_t;

    logic   clk = 1'b0;
    logic   n_rst = 1'b0;
    logic   req0_valid, req1_valid, req0_ready, req1_ready;
    aluop_t req0_aluop, req1_aluop, alu_aluop;
    word_t  req0_porta, req0_portb, req1_porta, req1_portb;
    word_t  alu_porta, alu_portb, alu_outport;
    logic   alu_negative, alu_zero, alu_overflow;
    logic   rsp_valid, rsp_ready, rsp_id;
    word_t  rsp_outport;
    logic   rsp_negative, rsp_zero, rsp_overflow;

    logic   fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
    aluop_t fp_alu_aluop;
    word_t  fp_alu_porta, fp_alu_portb, fp_rsp_outport;
    logic   fp_rsp_negative, fp_rsp_zero, fp_rsp_overflow;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   fp_viol = 0;
    int   fp_req0_seen = 0;
    vec_t exp_cur [2];
    sb_t  sb_q [$];
    logic served_ids [$];
    int   accept_log [$];
    logic issue_cycle = 1'b0;
    logic prev_rsp_valid = 1'b0;
    logic prev_n_rst = 1'b0;
    logic prev_v0 = 1'b0, prev_r0 = 1'b0, prev_v1 = 1'b0, prev_r1 = 1'b0;
    vec_t vecs [12];

    always #5 clk = ~clk;

    alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .CLK(clk), .nRST(n_rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_porta(req0_porta), .req0_portb(req0_portb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_porta(req1_porta), .req1_portb(req1_portb),
        .alu_aluop(alu_aluop), .alu_porta(alu_porta), .alu_portb(alu_portb),
        .alu_outport(alu_outport), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_outport(rsp_outport), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .CLK(clk), .nRST(n_rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_aluop(req0_aluop),
        .req0_porta(req0_porta), .req0_portb(req0_portb),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_aluop(req1_aluop),
        .req1_porta(req1_porta), .req1_portb(req1_portb),
        .alu_aluop(fp_alu_aluop), .alu_porta(fp_alu_porta), .alu_portb(fp_alu_portb),
        .alu_outport(alu_outport), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_outport(fp_rsp_outport), .rsp_negative(fp_rsp_negative), .rsp_zero(fp_rsp_zero),
        .rsp_overflow(fp_rsp_overflow)
    );

    // Behavioural ALU: shift amount from porta, shifted value from portb.
    always_comb begin
        word_t r;
        r = '0;
        alu_overflow = 1'b0;
        case (alu_aluop)
            ALU_SLL:  r = alu_portb << alu_porta[4:0];
            ALU_SRL:  r = alu_portb >> alu_porta[4:0];
            ALU_ADD: begin
                r = alu_porta + alu_portb;
                alu_overflow = (alu_porta[31] == alu_portb[31]) && (r[31] != alu_porta[31]);
            end
            ALU_SUB: begin
                r = alu_porta - alu_portb;
                alu_overflow = (alu_porta[31] != alu_portb[31]) && (r[31] != alu_porta[31]);
            end
            ALU_AND:  r = alu_porta & alu_portb;
            ALU_OR:   r = alu_porta | alu_portb;
            ALU_XOR:  r = alu_porta ^ alu_portb;
            ALU_NOR:  r = ~(alu_porta | alu_portb);
            ALU_SLT:  r = {31'd0, $signed(alu_porta) < $signed(alu_portb)};
            ALU_SLTU: r = {31'd0, alu_porta < alu_portb};
            default:  r = '0;
        endcase
        alu_outport  = r;
        alu_negative = r[31];
        alu_zero     = (r == 32'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or unexpected event (cycle %0d)", name, cycle);
    endtask

    // Drive one requester and hold valid until it has been accepted count times.
    task automatic applyStimulus(input vec_t v, input int count);
        int got = 0;
        int waited = 0;
        logic rdy;
        @(posedge clk);
        #1;
        exp_cur[v.id] = v;
        if (v.id == 1'b0) begin
            req0_aluop = v.op; req0_porta = v.a; req0_portb = v.b; req0_valid = 1'b1;
        end else begin
            req1_aluop = v.op; req1_porta = v.a; req1_portb = v.b; req1_valid = 1'b1;
        end
        while (got < count) begin
            @(negedge clk);
            rdy = (v.id == 1'b0) ? req0_ready : req1_ready;
            if (rdy) begin
                got++;
                waited = 0;
                @(posedge clk);
                #1;
            end else if (++waited > 200) begin
                failNow("request_timeout");
                got = count;
            end
        end
        if (v.id == 1'b0) req0_valid = 1'b0;
        else              req1_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rsp_valid) break;
            n++;
        end
        if (n >= 100) failNow("drain_timeout");
    endtask

    // Monitor: sees values that the next rising edge will sample.
    always @(negedge clk) begin
        logic hs0, hs1;
        sb_t  e;
        cycle = cycle + 1;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (issue_cycle && sb_q.size() > 0) begin
            checkOutput("alu_aluop_issue", 32'(alu_aluop), 32'(sb_q[$].vec.op));
            checkOutput("alu_porta_issue", alu_porta, sb_q[$].vec.a);
            checkOutput("alu_portb_issue", alu_portb, sb_q[$].vec.b);
        end else begin
            checkOutput("alu_aluop_idle", 32'(alu_aluop), 32'(ALU_ADD));
            checkOutput("alu_porta_idle", alu_porta, 32'd0);
            checkOutput("alu_portb_idle", alu_portb, 32'd0);
        end
        issue_cycle = 1'b0;
        if (!n_rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && !prev_rsp_valid) begin
                if (sb_q.size() == 0) failNow("unexpected_rsp_valid");
                else checkOutput("rsp_latency", 32'(cycle - sb_q[0].acc_cycle), 32'd2);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    failNow("unexpected_rsp_pop");
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.vec.id));
                    checkOutput("rsp_outport", rsp_outport, e.vec.out);
                    checkOutput("rsp_negative", 32'(rsp_negative), 32'(e.vec.n));
                    checkOutput("rsp_zero", 32'(rsp_zero), 32'(e.vec.z));
                    checkOutput("rsp_overflow", 32'(rsp_overflow), 32'(e.vec.v));
                    served_ids.push_back(rsp_id);
                end
            end
            if (hs0 && hs1) failNow("dual_grant");
            if (hs0) begin
                sb_q.push_back('{exp_cur[0], cycle});
                accept_log.push_back(cycle);
                issue_cycle = 1'b1;
            end
            if (hs1) begin
                sb_q.push_back('{exp_cur[1], cycle});
                accept_log.push_back(cycle);
                issue_cycle = 1'b1;
            end
            if (fp_req1_ready && req0_valid) fp_viol++;
            if (fp_req0_ready) fp_req0_seen++;
            if (prev_n_rst) begin
                assert (!(prev_v0 && !prev_r0 && !req0_valid)) else $error("[TB] req0 dropped valid before ready");
                assert (!(prev_v1 && !prev_r1 && !req1_valid)) else $error("[TB] req1 dropped valid before ready");
            end
        end
        prev_rsp_valid = rsp_valid;
        prev_n_rst = n_rst;
        prev_v0 = req0_valid; prev_r0 = req0_ready;
        prev_v1 = req1_valid; prev_r1 = req1_ready;
    end

    initial begin
        vec_t v_sub, v_or, v_slt, v_add, v_xor, v_sll, v_srl;
        logic exp_order [4];
        int   n;

        vecs[0]  = '{1'b0, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, aluop_t'(4'hF), 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, ALU_SLL,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, ALU_SRL,  32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        v_sub = '{1'b0, ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0};
        v_or  = '{1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        v_slt = '{1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        v_add = '{1'b0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0};
        v_xor = '{1'b0, ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 1'b0, 1'b0, 1'b0};
        v_sll = '{1'b1, ALU_SLL, 32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
        v_srl = '{1'b1, ALU_SRL, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

        // Reset with both requesters asserting valid: no ready, response cleared.
        rsp_ready = 1'b1;
        req0_aluop = ALU_ADD; req0_porta = 32'd1; req0_portb = 32'd1; req0_valid = 1'b1;
        req1_aluop = ALU_OR;  req1_porta = 32'd1; req1_portb = 32'd1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_req0_ready", 32'(req0_ready), 32'd0);
        checkOutput("reset_req1_ready", 32'(req1_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_rsp_outport", rsp_outport, 32'd0);
        checkOutput("reset_rsp_flags", {29'd0, rsp_negative, rsp_zero, rsp_overflow}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0; n_rst = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], 1);
            waitDrain();
        end

        $display("[TB] contention after reset");
        @(posedge clk); #1 n_rst = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1;
        served_ids.delete();
        fp_viol = 0;
        fp_req0_seen = 0;
        fork
            applyStimulus(v_sub, 2);
            applyStimulus(v_or, 2);
        join
        waitDrain();
        checkOutput("order_len", 32'(served_ids.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (served_ids.size() > i) checkOutput("order_id", 32'(served_ids[i]), 32'(exp_order[i]));
        end
        checkOutput("fixed_prio_req1_over_req0", 32'(fp_viol), 32'd0);
        checkOutput("fixed_prio_req0_granted", 32'(fp_req0_seen > 0), 32'd1);

        $display("[TB] response held with rsp_ready low");
        rsp_ready = 1'b0;
        applyStimulus(v_slt, 1);
        fork
            applyStimulus(v_add, 1);
            begin
                n = 0;
                while (!rsp_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!rsp_valid) failNow("hold_rsp_valid_wait");
                for (int i = 0; i < 10; i++) begin
                    checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                    checkOutput("hold_rsp_outport", rsp_outport, 32'd1);
                    checkOutput("hold_rsp_id", 32'(rsp_id), 32'd1);
                    checkOutput("hold_req0_ready", 32'(req0_ready), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset during ISSUE");
        applyStimulus(v_xor, 1);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("abort_rsp_outport", rsp_outport, 32'd0);
        checkOutput("abort_rsp_flags", {29'd0, rsp_negative, rsp_zero, rsp_overflow}, 32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        served_ids.delete();
        fork
            applyStimulus(v_add, 1);
            applyStimulus(v_or, 1);
        join
        waitDrain();
        checkOutput("post_reset_len", 32'(served_ids.size()), 32'd2);
        if (served_ids.size() > 0) checkOutput("post_reset_first_id", 32'(served_ids[0]), 32'd0);

        $display("[TB] back-to-back on req1");
        accept_log.delete();
        applyStimulus(v_sll, 1);
        applyStimulus(v_srl, 1);
        waitDrain();
        checkOutput("b2b_accepts", 32'(accept_log.size()), 32'd2);
        if (accept_log.size() == 2) checkOutput("b2b_gap", 32'(accept_log[1] - accept_log[0]), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
